// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetch front end
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_out,
  output logic            misaligned
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_TRAP = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] instr_next, instr_pc_next;
  logic            discard, discard_next;
  logic            misaligned_next;

  assign imem_addr = pc;
  assign pc_out    = pc;

  // State and datapath registers; synchronous active-low reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      misaligned <= 1'b0;
      instr      <= '0;
      instr_pc   <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      discard    <= discard_next;
      misaligned <= misaligned_next;
      instr      <= instr_next;
      instr_pc   <= instr_pc_next;
    end
  end

  // Next-state and outputs: redirects outrank the fetch/consume handshakes.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    discard_next    = discard;
    misaligned_next = misaligned;
    instr_next      = instr;
    instr_pc_next   = instr_pc;
    imem_req_valid  = (state == S_REQ);
    instr_valid     = (state == S_HOLD);

    if (state != S_TRAP && redirect_valid) begin
      pc_next = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        // Misaligned target: park until reset, any in-flight response is ignored.
        misaligned_next = 1'b1;
        discard_next    = 1'b0;
        state_next      = S_TRAP;
      end else begin
        case (state)
          S_REQ: begin
            // Request for the old PC was accepted this cycle; its response is stale.
            if (imem_req_ready) begin
              state_next   = S_WAIT;
              discard_next = 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              state_next   = S_REQ;
              discard_next = 1'b0;
            end else begin
              discard_next = 1'b1;
            end
          end
          default: state_next = S_REQ;
        endcase
      end
    end else begin
      case (state)
        S_IDLE: state_next = S_REQ;
        S_REQ: begin
          if (imem_req_ready) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (discard) begin
              discard_next = 1'b0;
              state_next   = S_REQ;
            end else begin
              instr_next    = imem_rsp_data;
              instr_pc_next = pc;
              state_next    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            pc_next    = pc + XLEN'(4);
            state_next = S_REQ;
          end
        end
        default: state_next = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic        misaligned;

  logic        w_req_valid, w_req_ready;
  logic [31:0] w_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_instr_valid, w_instr_ready;
  logic [31:0] w_instr, w_instr_pc;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_out;
  logic        w_misaligned;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .misaligned(misaligned)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .instr_valid(w_instr_valid),
    .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .pc_out(w_pc_out), .misaligned(w_misaligned)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
    w_instr_ready = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0;

    // Reset held for three cycles
    repeat (3) step();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_wrap_pc", w_pc_out, 32'hFFFF_FFFC);

    // Release: first request one cycle later
    rst = 1'b1;
    step();
    check("rel_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("rel_addr", imem_addr, 32'h0);
    check("rel_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rel_misaligned", {31'b0, misaligned}, 32'h0);

    // Sequential zero-wait fetch of 0x0 and 0x4, three cycles each
    for (int i = 0; i < 2; i++) begin
      check("seq_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("seq_addr", imem_addr, 32'(4 * i));
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      check("seq_wait_req_valid", {31'b0, imem_req_valid}, 32'h0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
      step();
      imem_rsp_valid = 1'b0;
      check("seq_instr_valid", {31'b0, instr_valid}, 32'h1);
      check("seq_instr", instr, 32'h0000_0013);
      check("seq_instr_pc", instr_pc, 32'(4 * i));
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      check("seq_next_instr_valid", {31'b0, instr_valid}, 32'h0);
    end

    // Request stall on 0x8: address must hold
    for (int i = 0; i < 4; i++) begin
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("stall_addr", imem_addr, 32'h8);
      step();
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("stall_wait_req_valid", {31'b0, imem_req_valid}, 32'h0);

    // Redirect to 0x100 while fetch of 0x8 is outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    check("rdw_pc", pc_out, 32'h100);
    check("rdw_req_valid", {31'b0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    check("rdw_stale_dropped", {31'b0, instr_valid}, 32'h0);
    check("rdw_req_valid2", {31'b0, imem_req_valid}, 32'h1);
    check("rdw_addr", imem_addr, 32'h100);

    // Fetch 0x100 with a two-cycle response delay
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    check("delay_iv0", {31'b0, instr_valid}, 32'h0);
    step();
    check("delay_iv1", {31'b0, instr_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    step();
    imem_rsp_valid = 1'b0;
    check("delay_iv_rise", {31'b0, instr_valid}, 32'h1);
    check("delay_instr", instr, 32'h0050_0093);
    check("delay_instr_pc", instr_pc, 32'h100);
    step();
    check("hold_iv", {31'b0, instr_valid}, 32'h1);
    check("hold_instr", instr, 32'h0050_0093);
    check("hold_instr_pc", instr_pc, 32'h100);

    // Redirect from HOLD without consume, to 0x20
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    check("rdh_iv", {31'b0, instr_valid}, 32'h0);
    check("rdh_addr", imem_addr, 32'h20);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    check("rdh_instr_pc", instr_pc, 32'h20);

    // Redirect to 0x40 together with consume: no fetch of 0x24
    redirect_valid = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    check("rdc_pc", pc_out, 32'h40);
    check("rdc_addr", imem_addr, 32'h40);
    check("rdc_iv", {31'b0, instr_valid}, 32'h0);

    // Redirect to 0x80 in the same cycle the request for 0x40 is accepted
    redirect_valid = 1'b1; redirect_pc = 32'h80; imem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    step();
    imem_rsp_valid = 1'b0;
    check("rdq_stale_dropped", {31'b0, instr_valid}, 32'h0);
    check("rdq_addr", imem_addr, 32'h80);
    check("rdq_req_valid", {31'b0, imem_req_valid}, 32'h1);

    // Misaligned redirect traps until reset
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    check("trap_misaligned", {31'b0, misaligned}, 32'h1);
    check("trap_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("trap_pc", pc_out, 32'h102);
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    check("trap_held_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("trap_held_iv", {31'b0, instr_valid}, 32'h0);
    check("trap_held_misaligned", {31'b0, misaligned}, 32'h1);
    check("trap_held_pc", pc_out, 32'h102);

    // Reset clears the trap
    rst = 1'b0;
    step();
    check("rst2_misaligned", {31'b0, misaligned}, 32'h0);
    check("rst2_pc", pc_out, 32'h0);
    check("rst2_req_valid", {31'b0, imem_req_valid}, 32'h0);
    rst = 1'b1;
    step();

    // Wrap: RESET_PC = 0xFFFFFFFC, consume one instruction
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check("wrap_req_valid0", {31'b0, w_req_valid}, 32'h1);
    w_req_ready = 1'b1;
    step();
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1; w_rsp_data = 32'h0000_0013;
    step();
    w_rsp_valid = 1'b0;
    check("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    w_instr_ready = 1'b1;
    step();
    w_instr_ready = 1'b0;
    check("wrap_addr1", w_addr, 32'h0);
    check("wrap_req_valid1", {31'b0, w_req_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
